sandbox_cmd_queue: RTL
======================

SANDBOX_CMD_QUEUE -- requirements
Module: sandbox_cmd_queue

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of the host data word, engine command data and response data.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the command FIFO entry count; legal values are 2, 4 or 8.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1024, meaning the cycles an outstanding engine command may wait for a response before abort; legal range is 2 to 2^20.

Interface
REQ-004 masterClock  in  1  is the single operating clock; all logic SHALL be on its rising edge.
REQ-005 reset  in  1  is the reset, which SHALL be asynchronous and active-high.
REQ-006 Host-side inputs:
- dataReceived  in  1  host word present.
- control  in  8  bit0 = push, bit1 = clear sticky flags.
- inputData  in  DATA_W  host word.
REQ-007 Host-side outputs:
- clearDR  out  1  host word consumed.
- transmitData  out  1  reply ready.
- status  out  8  reply status byte.
- outputData  out  DATA_W  reply data.
REQ-008 Engine-side ports:
- engValid  out  1  command valid.
- engControl  out  8  queued control byte.
- engData  out  DATA_W  queued data word.
- engReady  in  1  engine accepts the command.
- respValid  in  1  one-cycle response strobe.
- respData  in  DATA_W  response data.
- respFlag  in  1  engine result bit.

Function
REQ-009 The host FSM SHALL use states IDLE, TX, HOLD, CLR and WAIT.
REQ-010 The host FSM transitions SHALL be:
- IDLE to TX when dataReceived=1.
- TX, HOLD and CLR each advance unconditionally after 1 cycle.
- WAIT to IDLE when dataReceived=0.
REQ-011 Entering TX, the block SHALL register status and outputData and set transmitData=1.
REQ-012 Entering CLR, the block SHALL set clearDR=1.
REQ-013 Leaving WAIT, the block SHALL clear transmitData and clearDR together.
REQ-014 In IDLE with control[0]=1 (push): if the FIFO is not full, {control, inputData} SHALL be written; if it is full, the word SHALL be dropped and sticky overflow set; outputData SHALL be 0.
REQ-015 In IDLE with control[0]=0 (read): outputData SHALL equal respReg and the fresh bit SHALL be cleared after being reported.
REQ-016 When control[1]=1, sticky overflow and timeout SHALL clear after being reported in this reply.
REQ-017 The status byte SHALL be:
- bit0 = respFlagReg.
- bit1 = overflow.
- bit2 = fresh.
- bit3 = timeout.
- bits7:4 = FIFO occupancy after this command's push, zero-extended.
REQ-018 The dispatcher SHALL present the FIFO head on engValid/engControl/engData when the FIFO is non-empty and no command is outstanding.
REQ-019 The FIFO SHALL pop on engValid & engReady, which SHALL set outstanding=1 and zero the wait counter.
REQ-020 engValid SHALL stay asserted with its data stable until engReady.
REQ-021 While outstanding, respValid SHALL load respReg=respData and respFlagReg=respFlag, set fresh=1, and clear outstanding.
REQ-022 If outstanding reaches TIMEOUT_CYC cycles without respValid, the block SHALL clear outstanding, set sticky timeout, and leave respReg unchanged.
REQ-023 respValid while not outstanding SHALL be ignored.
REQ-024 If respValid and timeout expiry coincide, the response SHALL win and timeout SHALL not be set.
REQ-025 If a host push and an engine pop coincide with the FIFO full, the push SHALL be accepted with no overflow.
REQ-026 If a host read and respValid coincide, the reply SHALL carry the old respReg and fresh SHALL end at 1.
REQ-027 If a push and a clear-flags request occur in one command and that push overflows, overflow SHALL end at 1.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and occupancy SHALL range 0..FIFO_DEPTH.

Reset
REQ-029 While reset=1, the block SHALL hold:
- host FSM in IDLE.
- FIFO empty and outstanding=0.
- clearDR=0, transmitData=0, engValid=0.
- status=0, outputData=0, engControl=0, engData=0.
- respReg=0, all flags 0.
REQ-030 When reset asserts mid-operation, the block SHALL abort immediately, drop queued commands and ignore the outstanding response.

Verification
REQ-031 Scenario: push 0x11223344 with control=0x01, engReady=1, then respValid with respData=0xCAFEF00D and respFlag=1, then a read with control=0x00 -> push reply status=0x10; read reply outputData=0xCAFEF00D, status=0x05.
REQ-032 Scenario: 5 pushes, engReady=0, FIFO_DEPTH=4 -> 5th reply status=0x42; FIFO still holds the first 4 words in order.
REQ-033 Scenario: one command accepted, no response for 1024 cycles -> read reply has status bit3=1 and outputData unchanged; a read with control=0x02 reports bit3=1 and the next read reports bit3=0.
REQ-034 Scenario: respValid on the exact expiry cycle -> respReg loaded and timeout=0.
REQ-035 Scenario: transmitData high with dataReceived held 1 -> block stays in WAIT; drop dataReceived -> transmitData and clearDR go to 0 in 1 cycle.
REQ-036 Scenario: reset pulse with 3 words queued and 1 outstanding -> all outputs 0 and a later respValid is ignored (fresh=0).

Source files
------------

// File: rtl/sandbox_cmd_queue.sv
// Host command queue: the host pushes control/data words into a FIFO that is
// dispatched to an engine, and reads back the last engine response with status.
module sandbox_cmd_queue #(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              masterClock,
  input  logic              reset,
  input  logic              dataReceived,
  input  logic [7:0]        control,
  input  logic [DATA_W-1:0] inputData,
  output logic              clearDR,
  output logic              transmitData,
  output logic [7:0]        status,
  output logic [DATA_W-1:0] outputData,
  output logic              engValid,
  output logic [7:0]        engControl,
  output logic [DATA_W-1:0] engData,
  input  logic              engReady,
  input  logic              respValid,
  input  logic [DATA_W-1:0] respData,
  input  logic              respFlag
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int EW = DATA_W + 8;

  typedef enum logic [2:0] {
    IDLE,
    TX,
    HOLD,
    CLR,
    WAIT
  } state_t;

  state_t            r_state;
  logic [EW-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [CW-1:0]     r_cnt;
  logic              r_outst;
  logic [TW-1:0]     r_wait;
  logic [DATA_W-1:0] r_resp;
  logic              r_flag;
  logic              r_fresh;
  logic              r_ovf;
  logic              r_tmo;

  logic              w_eng_valid;
  logic              w_pop;
  logic              w_cmd;
  logic              w_push_req;
  logic              w_full;
  logic              w_push;
  logic              w_ovf_new;
  logic              w_clr_flags;
  logic              w_resp;
  logic              w_expire;
  logic [CW-1:0]     w_cnt_nxt;
  logic [EW-1:0]     w_head;

  assign w_head      = r_mem[r_rd];
  assign w_eng_valid = (r_cnt != '0) && !r_outst;
  assign w_pop       = w_eng_valid && engReady;
  assign w_cmd       = (r_state == IDLE) && dataReceived;
  assign w_push_req  = w_cmd && control[0];
  assign w_clr_flags = w_cmd && control[1];
  assign w_full      = (r_cnt == CW'(FIFO_DEPTH));
  // A pop on the same edge frees the slot a full FIFO needs.
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_ovf_new   = w_push_req && !w_push;
  assign w_cnt_nxt   = r_cnt + CW'(w_push) - CW'(w_pop);
  assign w_resp      = r_outst && respValid;
  assign w_expire    = r_outst && !respValid &&
                       (r_wait == TW'(TIMEOUT_CYC - 1));

  assign engValid   = w_eng_valid;
  assign engControl = w_eng_valid ? w_head[EW-1:DATA_W] : '0;
  assign engData    = w_eng_valid ? w_head[DATA_W-1:0] : '0;

  always_ff @(posedge masterClock) begin
    if (w_push) begin
      r_mem[r_wr] <= {control, inputData};
    end
  end

  always_ff @(posedge masterClock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      transmitData <= 1'b0;
      clearDR      <= 1'b0;
      status       <= '0;
      outputData   <= '0;
      r_wr         <= '0;
      r_rd         <= '0;
      r_cnt        <= '0;
      r_outst      <= 1'b0;
      r_wait       <= '0;
      r_resp       <= '0;
      r_flag       <= 1'b0;
      r_fresh      <= 1'b0;
      r_ovf        <= 1'b0;
      r_tmo        <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (dataReceived) begin
            r_state      <= TX;
            transmitData <= 1'b1;
            status       <= {4'(w_cnt_nxt), r_tmo, r_fresh,
                             r_ovf | w_ovf_new, r_flag};
            outputData   <= control[0] ? '0 : r_resp;
          end
        end
        TX:   r_state <= HOLD;
        HOLD: begin
          r_state <= CLR;
          clearDR <= 1'b1;
        end
        CLR:  r_state <= WAIT;
        WAIT: begin
          if (!dataReceived) begin
            r_state      <= IDLE;
            transmitData <= 1'b0;
            clearDR      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= w_cnt_nxt;

      if (w_pop) begin
        r_outst <= 1'b1;
        r_wait  <= '0;
      end else if (r_outst) begin
        if (respValid || w_expire) r_outst <= 1'b0;
        else                       r_wait  <= r_wait + 1'b1;
      end

      if (w_resp) begin
        r_resp <= respData;
        r_flag <= respFlag;
      end

      // New events win over a same-cycle report-and-clear.
      if (w_resp)                          r_fresh <= 1'b1;
      else if (w_cmd && !control[0])       r_fresh <= 1'b0;
      if (w_ovf_new)                       r_ovf   <= 1'b1;
      else if (w_clr_flags)                r_ovf   <= 1'b0;
      if (w_expire)                        r_tmo   <= 1'b1;
      else if (w_clr_flags)                r_tmo   <= 1'b0;
    end
  end

endmodule
